// File: rtl/prog_loader_pkg.sv
// Shared encodings for the serial program loader: FSM states, frame sync byte,
// abort cause codes.
`ifndef INS_START_ADDRESS
`define INS_START_ADDRESS 32'h0000_0000
`endif

package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_LINK = 2'd3;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// rx_valid / rx_ferr pulses.
module uart_rx_8n1
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     rs;
  logic          sync1, sync2, prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b1;
      rs       <= RX_IDLE;
      cnt      <= '0;
      bitn     <= '0;
      shreg    <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      sync1    <= rx;
      sync2    <= sync1;
      prev     <= sync2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rs)
        RX_IDLE: begin
          cnt <= '0;
          if (prev && !sync2) rs <= RX_START;
        end
        RX_START: begin
          // A start bit that is gone by mid-bit was a glitch.
          if (cnt == HALF) begin
            cnt  <= '0;
            bitn <= '0;
            rs   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[7:1]};
            if (bitn == 3'd7) rs <= RX_STOP;
            else              bitn <= bitn + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            rs  <= RX_IDLE;
            if (sync2) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rs <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives an A5/length/payload/checksum frame over UART
// and writes the payload byte-by-byte into instruction memory from BASE_ADDR.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT   = 434,
  parameter logic [31:0] BASE_ADDR      = `INS_START_ADDRESS,
  parameter int          MAX_BYTES      = 1000,
  parameter int          TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset_n,
  input  logic        uart_rx,
  output logic        PC_to_mem_enable,
  output logic [7:0]  PC_to_mem_data,
  output logic [31:0] PC_to_mem_address,
  output logic        busy,
  output logic        load_done,
  output logic        load_error,
  output logic [1:0]  err_code
);

  localparam logic [31:0] TMAX = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] LMAX = 32'(MAX_BYTES);

  logic        rx_valid, rx_ferr;
  logic [7:0]  rx_byte;

  load_state_t state;
  logic [31:0] len, idx, tcnt;
  logic [7:0]  acc;
  logic [1:0]  lcnt;
  logic [31:0] len_next;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (SYS_clk),
    .rst_n    (SYS_reset_n),
    .rx       (uart_rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

  assign len_next = {len[23:0], rx_byte};

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state             <= S_IDLE;
      len               <= '0;
      idx               <= '0;
      tcnt              <= '0;
      acc               <= '0;
      lcnt              <= '0;
      PC_to_mem_enable  <= 1'b0;
      PC_to_mem_data    <= '0;
      PC_to_mem_address <= '0;
      busy              <= 1'b0;
      load_done         <= 1'b0;
      load_error        <= 1'b0;
      err_code          <= ERR_NONE;
    end else begin
      PC_to_mem_enable <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          tcnt <= '0;
          if (rx_valid && rx_byte == SYNC_BYTE) begin
            state      <= S_LEN;
            busy       <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            err_code   <= ERR_NONE;
            len        <= '0;
            idx        <= '0;
            acc        <= '0;
            lcnt       <= '0;
          end
        end
        default: begin
          if (rx_ferr) begin
            state      <= S_ERR;
            busy       <= 1'b0;
            load_error <= 1'b1;
            err_code   <= ERR_LINK;
          end else if (rx_valid) begin
            tcnt <= '0;
            case (state)
              S_LEN: begin
                len  <= len_next;
                lcnt <= lcnt + 1'b1;
                if (lcnt == 2'd3) begin
                  if (len_next == '0 || len_next > LMAX) begin
                    state      <= S_ERR;
                    busy       <= 1'b0;
                    load_error <= 1'b1;
                    err_code   <= ERR_LEN;
                  end else begin
                    state <= S_DATA;
                  end
                end
              end
              S_DATA: begin
                PC_to_mem_enable  <= 1'b1;
                PC_to_mem_data    <= rx_byte;
                PC_to_mem_address <= BASE_ADDR + idx;
                idx               <= idx + 32'd1;
                acc               <= acc + rx_byte;
                if (idx == len - 32'd1) state <= S_CSUM;
              end
              default: begin
                busy <= 1'b0;
                if (rx_byte == acc) begin
                  state     <= S_DONE;
                  load_done <= 1'b1;
                end else begin
                  state      <= S_ERR;
                  load_error <= 1'b1;
                  err_code   <= ERR_CSUM;
                end
              end
            endcase
          end else if (tcnt == TMAX) begin
            // Inter-byte gap too long: treat as a dead link.
            state      <= S_ERR;
            busy       <= 1'b0;
            load_error <= 1'b1;
            err_code   <= ERR_LINK;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: UART frames bit-banged at 16 clocks per bit.
module tb_prog_loader;

  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        PC_to_mem_enable;
  logic [7:0]  PC_to_mem_data;
  logic [31:0] PC_to_mem_address;
  logic        busy, load_done, load_error;
  logic [1:0]  err_code;

  int test_cnt = 0;
  int fail_cnt = 0;
  int rxv_cnt  = 0;

  logic [31:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  frame[$];

  prog_loader #(
    .CLKS_PER_BIT   (CPB),
    .BASE_ADDR      (BASE),
    .MAX_BYTES      (1000),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .SYS_clk           (SYS_clk),
    .SYS_reset_n       (SYS_reset_n),
    .uart_rx           (uart_rx),
    .PC_to_mem_enable  (PC_to_mem_enable),
    .PC_to_mem_data    (PC_to_mem_data),
    .PC_to_mem_address (PC_to_mem_address),
    .busy              (busy),
    .load_done         (load_done),
    .load_error        (load_error),
    .err_code          (err_code)
  );

  always #5 SYS_clk = ~SYS_clk;

  always @(negedge SYS_clk) begin
    if (PC_to_mem_enable) begin
      wa.push_back(PC_to_mem_address);
      wd.push_back(PC_to_mem_data);
    end
    if (dut.u_rx.rx_valid) rxv_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge SYS_clk) uart_rx = 1'b0;
    repeat (CPB) @(negedge SYS_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge SYS_clk);
    end
    uart_rx = 1'b1;
    repeat (CPB + 8) @(negedge SYS_clk);
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
    repeat (4) @(negedge SYS_clk);
  endtask

  task automatic test_reset();
    SYS_reset_n = 1'b0;
    repeat (3) @(negedge SYS_clk);
    test_cnt++; if (PC_to_mem_enable !== 1'b0) begin fail_cnt++; $display("FAIL reset_en got %b want 0", PC_to_mem_enable); end
    test_cnt++; if (PC_to_mem_data !== 8'h00) begin fail_cnt++; $display("FAIL reset_data got %h want 00", PC_to_mem_data); end
    test_cnt++; if (PC_to_mem_address !== 32'h0) begin fail_cnt++; $display("FAIL reset_addr got %h want 0", PC_to_mem_address); end
    test_cnt++; if ({busy, load_done, load_error, err_code} !== 5'b0) begin fail_cnt++; $display("FAIL reset_status got %b want 00000", {busy, load_done, load_error, err_code}); end
    SYS_reset_n = 1'b1;
    repeat (3) @(negedge SYS_clk);
  endtask

  task automatic test_load();
    logic [7:0] exp_d[4] = '{8'h13, 8'h00, 8'h00, 8'h93};
    wa.delete(); wd.delete();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h00, 8'h00, 8'h93, 8'hA6};
    send_frame();
    test_cnt++; if (wa.size() != 4) begin fail_cnt++; $display("FAIL load_nwrites got %0d want 4", wa.size()); end
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      test_cnt++;
      if (wa[i] !== BASE + 32'(i) || wd[i] !== exp_d[i]) begin
        fail_cnt++; $display("FAIL load_write%0d got %h@%h want %h@%h", i, wd[i], wa[i], exp_d[i], BASE + 32'(i));
      end
    end
    test_cnt++; if ({load_done, load_error, busy} !== 3'b100) begin fail_cnt++; $display("FAIL load_flags got done/err/busy %b want 100", {load_done, load_error, busy}); end
    test_cnt++; if (PC_to_mem_address !== BASE + 32'd3 || PC_to_mem_data !== 8'h93) begin fail_cnt++; $display("FAIL load_hold got %h@%h want 93@%h", PC_to_mem_data, PC_to_mem_address, BASE + 32'd3); end
  endtask

  task automatic test_bad_csum();
    wa.delete(); wd.delete();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h00, 8'h00, 8'h93, 8'hA7};
    send_frame();
    test_cnt++; if (wa.size() != 4) begin fail_cnt++; $display("FAIL csum_nwrites got %0d want 4", wa.size()); end
    test_cnt++; if ({load_done, load_error, err_code, busy} !== 5'b01100) begin fail_cnt++; $display("FAIL csum_flags got done/err/code/busy %b want 01100", {load_done, load_error, err_code, busy}); end
  endtask

  task automatic test_bad_len();
    wa.delete(); wd.delete();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'hE9};
    send_frame();
    test_cnt++; if ({load_done, load_error, err_code, busy} !== 5'b01010) begin fail_cnt++; $display("FAIL len_flags got done/err/code/busy %b want 01010", {load_done, load_error, err_code, busy}); end
    frame = '{8'h01, 8'h02};
    send_frame();
    test_cnt++; if (wa.size() != 0) begin fail_cnt++; $display("FAIL len_nwrites got %0d want 0", wa.size()); end
  endtask

  task automatic test_noise();
    int rx_before;
    wa.delete(); wd.delete();
    rx_before = rxv_cnt;
    @(negedge SYS_clk) uart_rx = 1'b0;
    repeat (3) @(negedge SYS_clk);
    uart_rx = 1'b1;
    repeat (10 * CPB) @(negedge SYS_clk);
    test_cnt++; if (rxv_cnt != rx_before) begin fail_cnt++; $display("FAIL glitch_bytes got %0d want %0d", rxv_cnt, rx_before); end
    frame = '{8'h5A, 8'h11};
    send_frame();
    test_cnt++; if ({busy, load_error, err_code} !== 4'b0101) begin fail_cnt++; $display("FAIL noise_ignored got busy/err/code %b want 0101", {busy, load_error, err_code}); end
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h03, 8'h02};
    send_frame();
    test_cnt++; if (wa.size() != 2) begin fail_cnt++; $display("FAIL noise_nwrites got %0d want 2", wa.size()); end
    else begin
      test_cnt++; if (wd[1] !== 8'h03 || wa[1] !== BASE + 32'd1) begin fail_cnt++; $display("FAIL noise_write1 got %h@%h want 03@%h", wd[1], wa[1], BASE + 32'd1); end
    end
    test_cnt++; if ({load_done, load_error, err_code} !== 4'b1000) begin fail_cnt++; $display("FAIL noise_flags got %b want 1000", {load_done, load_error, err_code}); end
  endtask

  task automatic test_timeout();
    int waited;
    wa.delete(); wd.delete();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h00};
    send_frame();
    repeat (900) @(negedge SYS_clk);
    test_cnt++; if ({busy, load_error} !== 2'b10) begin fail_cnt++; $display("FAIL tmo_early got busy/err %b want 10", {busy, load_error}); end
    waited = 0;
    while (!load_error && waited < 300) begin @(negedge SYS_clk); waited++; end
    test_cnt++; if ({load_error, err_code, busy} !== 4'b1110) begin fail_cnt++; $display("FAIL tmo_flags got err/code/busy %b want 1110 after %0d cycles", {load_error, err_code, busy}, waited); end
    test_cnt++; if (wa.size() != 2) begin fail_cnt++; $display("FAIL tmo_nwrites got %0d want 2", wa.size()); end
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h7E, 8'h7E};
    send_frame();
    test_cnt++; if ({load_done, load_error, err_code} !== 4'b1000) begin fail_cnt++; $display("FAIL tmo_recover got %b want 1000", {load_done, load_error, err_code}); end
  endtask

  task automatic test_async_reset();
    wa.delete(); wd.delete();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h22};
    send_frame();
    test_cnt++; if (busy !== 1'b1 || PC_to_mem_data !== 8'h22) begin fail_cnt++; $display("FAIL arst_pre got busy %b data %h want 1 22", busy, PC_to_mem_data); end
    @(negedge SYS_clk);
    #2 SYS_reset_n = 1'b0;
    #1;
    test_cnt++; if ({busy, load_done, load_error, err_code, PC_to_mem_enable} !== 6'b0 || PC_to_mem_data !== 8'h00 || PC_to_mem_address !== 32'h0) begin
      fail_cnt++; $display("FAIL arst_out got status %b data %h addr %h want zeros", {busy, load_done, load_error, err_code, PC_to_mem_enable}, PC_to_mem_data, PC_to_mem_address);
    end
    repeat (2) @(negedge SYS_clk);
    SYS_reset_n = 1'b1;
    repeat (2) @(negedge SYS_clk);
    wa.delete(); wd.delete();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'hF0, 8'h20, 8'h10};
    send_frame();
    test_cnt++; if (wa.size() != 2) begin fail_cnt++; $display("FAIL arst_nwrites got %0d want 2", wa.size()); end
    else begin
      test_cnt++; if (wa[0] !== BASE || wd[0] !== 8'hF0) begin fail_cnt++; $display("FAIL arst_write0 got %h@%h want f0@%h", wd[0], wa[0], BASE); end
    end
    test_cnt++; if ({load_done, load_error, busy} !== 3'b100) begin fail_cnt++; $display("FAIL arst_flags got %b want 100", {load_done, load_error, busy}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_csum();
    test_bad_len();
    test_noise();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
